uart_rx_buffer: RTL

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer_pkg.sv | 14 +
 rtl/uart_rx_buffer_byte_fifo.sv | 60 ++++++
 rtl/uart_rx_buffer.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// Shared constants for the uart modules: receive-capture FSM encodings and the
// default receive buffer depth.
package uart_rx_buffer_pkg;

    localparam int UART_RX_DEPTH  = 8;
    localparam int UART_RX_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_rx_buffer_byte_fifo.sv
// Byte FIFO with show-ahead output: dout is mem[rd_ptr] combinationally.
// Full/empty come from the occupancy count; pointers wrap modulo DEPTH.
module byte_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              l_ready_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_pop;
    logic              w_push;

    assign full  = (r_count == (ADDR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push into a full buffer is only accepted when a pop frees a slot on the same edge.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: handshakes each byte from the UART receiver with a one-cycle
// ack pulse, stores it in a byte FIFO and flags bytes dropped while full.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = UART_RX_DEPTH,
    parameter int ADDR_W = UART_RX_ADDR_W
) (
    input  logic              clk,
    input  logic              l_ready_reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              rx_ack,
    output logic [7:0]        dout,
    output logic              valid,
    input  logic              pop,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clear_overflow
);

    rx_state_t r_state;
    logic      r_rx_ack;
    logic      r_overflow;
    logic      w_capture;
    logic      w_pop_ok;
    logic      w_drop;
    logic      w_empty;
    logic      w_full;

    assign w_capture = (r_state == ST_IDLE) && rx_ready;
    assign w_pop_ok  = pop && !w_empty;
    // A capture while full is lost unless a pop makes room on the same edge.
    assign w_drop    = w_capture && w_full && !w_pop_ok;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk           (clk),
        .l_ready_reset (l_ready_reset),
        .push          (w_capture),
        .pop           (pop),
        .din           (rx_data),
        .dout          (dout),
        .count         (count),
        .full          (w_full),
        .empty         (w_empty)
    );

    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) begin
            r_state    <= ST_IDLE;
            r_rx_ack   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rx_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_ready) begin
                        r_state  <= ST_ACK;
                        r_rx_ack <= 1'b1;
                    end
                end
                ST_ACK:  r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (!rx_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rx_ack   = r_rx_ack;
    assign overflow = r_overflow;
    assign valid    = !w_empty;
    assign full     = w_full;

endmodule
